// File: rtl/periph_timer_pkg.sv
// Shared peripheral definitions for the timer: register window layout,
// TCON bit positions and the data-memory address decoder.
package periph_timer_pkg;

  localparam logic [31:0] DEFAULT_BASE = 32'h4000_0000;

  localparam logic [31:0] TH_OFF      = 32'h0000_0000;
  localparam logic [31:0] TL_OFF      = 32'h0000_0004;
  localparam logic [31:0] TCON_OFF    = 32'h0000_0008;
  localparam logic [31:0] SYSTICK_OFF = 32'h0000_000C;

  localparam int TCON_EN_BIT     = 0;
  localparam int TCON_IE_BIT     = 1;
  localparam int TCON_STATUS_BIT = 2;

  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_TH,
    REG_TL,
    REG_TCON,
    REG_SYSTICK
  } regSel_e;

  // Word-granular decode: byte lanes are not part of the register select.
  function automatic regSel_e decodeReg(input logic [29:0] baseWord,
                                        input logic [29:0] addrWord);
    logic [31:0] off;
    regSel_e     sel;
    off = {addrWord - baseWord, 2'b00};
    case (off)
      TH_OFF:      sel = REG_TH;
      TL_OFF:      sel = REG_TL;
      TCON_OFF:    sel = REG_TCON;
      SYSTICK_OFF: sel = REG_SYSTICK;
      default:     sel = REG_NONE;
    endcase
    decodeReg = sel;
  endfunction

endpackage

// File: rtl/periph_timer_if.sv
// Data-memory bus bundle between the core (master) and a peripheral (slave).
interface periph_timer_if;

  logic        iRd;
  logic        iWr;
  logic [31:0] iAddr;
  logic [31:0] iWrData;
  logic [31:0] oRdData;
  logic        oAccessable;

  modport master (
    output iRd, iWr, iAddr, iWrData,
    input  oRdData, oAccessable
  );

  modport slave (
    input  iRd, iWr, iAddr, iWrData,
    output oRdData, oAccessable
  );

endinterface

// File: rtl/timer_counter.sv
// TL up-counter with auto-reload from TH; bus loads of TL take priority.
module timer_counter
  import periph_timer_pkg::*;
(
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iEn,
  input  logic [31:0] iTh,
  input  logic        iLoad,
  input  logic [31:0] iLoadData,
  output logic [31:0] oTl,
  output logic        oOverflow
);

  // Overflow is the cycle in which TL sits at its maximum while enabled;
  // the reload and the STATUS set both happen at the edge that ends it.
  assign oOverflow = iEn && (oTl == COUNT_MAX);

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oTl <= '0;
    end else if (iLoad) begin
      oTl <= iLoadData;
    end else if (oOverflow) begin
      oTl <= iTh;
    end else if (iEn) begin
      oTl <= oTl + 32'd1;
    end
  end

endmodule

// File: rtl/periph_timer.sv
// Memory-mapped timer: TH/TL reload counter, TCON control/status, free-running
// SYSTICK, combinational read mux and level interrupt.
module periph_timer
  import periph_timer_pkg::*;
#(
  parameter logic [31:0] BASE = DEFAULT_BASE
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iRd,
  input  logic        iWr,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWrData,
  output logic [31:0] oRdData,
  output logic        oAccessable,
  output logic        oIrq
);

  regSel_e     regSel;
  logic [31:0] th;
  logic [31:0] tl;
  logic [31:0] sysTick;
  logic        tconEn;
  logic        tconIe;
  logic        tconStatus;
  logic        overflow;
  logic        wrTh;
  logic        wrTl;
  logic        wrTcon;
  logic [31:0] tconWord;
  logic [1:0]  unusedAddrBits;

  assign unusedAddrBits = iAddr[1:0];

  assign regSel      = decodeReg(BASE[31:2], iAddr[31:2]);
  assign oAccessable = (regSel != REG_NONE);

  assign wrTh   = iWr && (regSel == REG_TH);
  assign wrTl   = iWr && (regSel == REG_TL);
  assign wrTcon = iWr && (regSel == REG_TCON);

  always_comb begin
    tconWord                  = '0;
    tconWord[TCON_EN_BIT]     = tconEn;
    tconWord[TCON_IE_BIT]     = tconIe;
    tconWord[TCON_STATUS_BIT] = tconStatus;
  end

  always_comb begin
    oRdData = '0;
    if (iRd) begin
      case (regSel)
        REG_TH:      oRdData = th;
        REG_TL:      oRdData = tl;
        REG_TCON:    oRdData = tconWord;
        REG_SYSTICK: oRdData = sysTick;
        default:     oRdData = '0;
      endcase
    end
  end

  timer_counter uCounter (
    .iClk      (iClk),
    .iRst_n    (iRst_n),
    .iEn       (tconEn),
    .iTh       (th),
    .iLoad     (wrTl),
    .iLoadData (iWrData),
    .oTl       (tl),
    .oOverflow (overflow)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      th <= '0;
    end else if (wrTh) begin
      th <= iWrData;
    end
  end

  // Hardware overflow beats a software clear of STATUS in the same cycle.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      tconEn     <= 1'b0;
      tconIe     <= 1'b0;
      tconStatus <= 1'b0;
    end else if (wrTcon) begin
      tconEn     <= iWrData[TCON_EN_BIT];
      tconIe     <= iWrData[TCON_IE_BIT];
      tconStatus <= iWrData[TCON_STATUS_BIT] | overflow;
    end else begin
      tconStatus <= tconStatus | overflow;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      sysTick <= '0;
    end else begin
      sysTick <= sysTick + 32'd1;
    end
  end

  assign oIrq = tconIe & tconStatus;

endmodule

// File: tb/tb_periph_timer.sv
// Self-checking bench for periph_timer: register table, overflow timing,
// STATUS/TL write races, SYSTICK and asynchronous reset.
module tb_periph_timer;
  import periph_timer_pkg::*;

  localparam logic [31:0] B = DEFAULT_BASE;

  typedef struct {
    logic [31:0] data;
    logic        acc;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRd;
    logic        expAcc;
    logic        expIrq;
  } vec_t;

  logic        clk;
  logic        rstN;
  logic        irq;
  logic [31:0] tbTick;
  int          tests;
  int          fails;
  exp_t        sb[$];
  vec_t        tbl[9];

  periph_timer_if bus();

  periph_timer #(.BASE(B)) dut (
    .iClk        (clk),
    .iRst_n      (rstN),
    .iRd         (bus.iRd),
    .iWr         (bus.iWr),
    .iAddr       (bus.iAddr),
    .iWrData     (bus.iWrData),
    .oRdData     (bus.oRdData),
    .oAccessable (bus.oAccessable),
    .oIrq        (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference cycle count since reset release, the expected SYSTICK value.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) tbTick <= '0;
    else       tbTick <= tbTick + 32'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", n, act, expv);
    end
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input logic acc, input string n);
    exp_t x;
    bus.iRd   = 1'b1;
    bus.iAddr = a;
    sb.push_back('{data: e, acc: acc});
    #1;
    x = sb.pop_front();
    chk({n, "_data"}, bus.oRdData, x.data);
    chk({n, "_acc"}, {31'b0, bus.oAccessable}, {31'b0, x.acc});
    bus.iRd = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.iWr     = 1'b1;
    bus.iAddr   = a;
    bus.iWrData = d;
    @(posedge clk);
    #1;
    bus.iWr = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    rstN        = 1'b0;
    bus.iRd     = 1'b0;
    bus.iWr     = 1'b0;
    bus.iAddr   = '0;
    bus.iWrData = '0;

    tbl[0] = '{"th",       B + 32'h0,  32'hA5A5_5A5A, 32'hA5A5_5A5A, 1'b1, 1'b0};
    tbl[1] = '{"tl",       B + 32'h4,  32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0};
    tbl[2] = '{"tcon_ie",  B + 32'h8,  32'hFFFF_FFFA, 32'h0000_0002, 1'b1, 1'b0};
    tbl[3] = '{"tcon_st",  B + 32'h8,  32'h0000_0004, 32'h0000_0004, 1'b1, 1'b0};
    tbl[4] = '{"tcon_irq", B + 32'h8,  32'h0000_0006, 32'h0000_0006, 1'b1, 1'b1};
    tbl[5] = '{"tcon_clr", B + 32'h8,  32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    tbl[6] = '{"unmap_hi", B + 32'h10, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0};
    tbl[7] = '{"th_lanes", B + 32'h3,  32'h0000_CAFE, 32'h0000_CAFE, 1'b1, 1'b0};
    tbl[8] = '{"unmap_lo", B - 32'h4,  32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0};

    // Reset state, checked while reset is still asserted.
    @(posedge clk);
    #1;
    rd(B + 32'h8, 32'h0, 1'b1, "rst_tcon");
    rd(B + 32'h0, 32'h0, 1'b1, "rst_th");
    chk("rst_irq", {31'b0, irq}, 32'h0);
    rd(B + 32'h10, 32'h0, 1'b0, "rst_unmap");
    cyc(1);
    rstN = 1'b1;
    cyc(1);

    foreach (tbl[i]) begin
      wr(tbl[i].addr, tbl[i].wdata);
      rd(tbl[i].addr, tbl[i].expRd, tbl[i].expAcc, tbl[i].name);
      chk({tbl[i].name, "_irq"}, {31'b0, irq}, {31'b0, tbl[i].expIrq});
    end

    // TH writes leave TL alone; unmapped writes had no effect.
    rd(B + 32'h4, 32'h1234_5678, 1'b1, "tl_kept");
    rd(B + 32'h0, 32'h0000_CAFE, 1'b1, "th_kept");

    bus.iAddr = B + 32'h4;
    #1;
    chk("nord_data", bus.oRdData, 32'h0);
    chk("nord_acc", {31'b0, bus.oAccessable}, 32'h1);

    // Simultaneous read and write returns the old value.
    bus.iRd     = 1'b1;
    bus.iWr     = 1'b1;
    bus.iAddr   = B;
    bus.iWrData = 32'h22;
    sb.push_back('{data: 32'h0000_CAFE, acc: 1'b1});
    #1;
    begin
      exp_t x;
      x = sb.pop_front();
      chk("rdwr_old", bus.oRdData, x.data);
    end
    @(posedge clk);
    #1;
    bus.iRd = 1'b0;
    bus.iWr = 1'b0;
    rd(B + 32'h0, 32'h22, 1'b1, "rdwr_new");

    // SYSTICK ignores writes and advances once per cycle.
    rd(B + 32'hC, tbTick, 1'b1, "systick_a");
    wr(B + 32'hC, 32'hDEAD_BEEF);
    rd(B + 32'hC, tbTick, 1'b1, "systick_wr");
    cyc(3);
    rd(B + 32'hC, tbTick, 1'b1, "systick_b");

    // Overflow timing and reload period.
    wr(B + 32'h0, 32'hFFFF_FFF0);
    wr(B + 32'h4, 32'hFFFF_FFFE);
    wr(B + 32'h8, 32'h3);
    rd(B + 32'h4, 32'hFFFF_FFFE, 1'b1, "ovf_start");
    chk("ovf_irq0", {31'b0, irq}, 32'h0);
    cyc(1);
    rd(B + 32'h4, 32'hFFFF_FFFF, 1'b1, "ovf_max");
    rd(B + 32'h8, 32'h3, 1'b1, "ovf_pre_st");
    cyc(1);
    rd(B + 32'h4, 32'hFFFF_FFF0, 1'b1, "ovf1_tl");
    rd(B + 32'h8, 32'h7, 1'b1, "ovf1_st");
    chk("ovf1_irq", {31'b0, irq}, 32'h1);
    wr(B + 32'h8, 32'h3);
    rd(B + 32'h8, 32'h3, 1'b1, "clr_st");
    chk("clr_irq", {31'b0, irq}, 32'h0);
    rd(B + 32'h4, 32'hFFFF_FFF1, 1'b1, "clr_tl");
    cyc(14);
    rd(B + 32'h4, 32'hFFFF_FFFF, 1'b1, "ovf2_pre_tl");
    rd(B + 32'h8, 32'h3, 1'b1, "ovf2_pre_st");
    cyc(1);
    rd(B + 32'h4, 32'hFFFF_FFF0, 1'b1, "ovf2_tl");
    rd(B + 32'h8, 32'h7, 1'b1, "ovf2_st");

    // Software clear in the overflow cycle loses to the hardware set.
    cyc(15);
    rd(B + 32'h4, 32'hFFFF_FFFF, 1'b1, "race_pre");
    wr(B + 32'h8, 32'h3);
    rd(B + 32'h8, 32'h7, 1'b1, "race_st");
    chk("race_irq", {31'b0, irq}, 32'h1);
    rd(B + 32'h4, 32'hFFFF_FFF0, 1'b1, "race_tl");
    wr(B + 32'h8, 32'h3);
    rd(B + 32'h8, 32'h3, 1'b1, "race_clr");
    chk("race_clr_irq", {31'b0, irq}, 32'h0);

    // TL bus write in the overflow cycle wins; STATUS still sets.
    cyc(14);
    rd(B + 32'h4, 32'hFFFF_FFFF, 1'b1, "tlw_pre");
    wr(B + 32'h4, 32'h1234);
    rd(B + 32'h4, 32'h1234, 1'b1, "tlw_tl");
    rd(B + 32'h8, 32'h7, 1'b1, "tlw_st");
    cyc(1);
    rd(B + 32'h4, 32'h1235, 1'b1, "tlw_next");

    // Asynchronous reset between edges while counting.
    #1;
    rstN = 1'b0;
    #1;
    rd(B + 32'h4, 32'h0, 1'b1, "arst_tl");
    rd(B + 32'h0, 32'h0, 1'b1, "arst_th");
    rd(B + 32'h8, 32'h0, 1'b1, "arst_tcon");
    rd(B + 32'hC, 32'h0, 1'b1, "arst_systick");
    chk("arst_irq", {31'b0, irq}, 32'h0);
    rstN = 1'b1;
    cyc(3);
    rd(B + 32'h4, 32'h0, 1'b1, "post_tl");
    rd(B + 32'h8, 32'h0, 1'b1, "post_tcon");
    rd(B + 32'hC, 32'h3, 1'b1, "post_systick");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/periph_timer.md
PERIPH_TIMER -- requirements
Module: periph_timer

Interface
REQ-001 SHALL have port iClk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port iRst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port iRd, input, 1, read strobe from the core's data-memory bus.
REQ-004 SHALL have port iWr, input, 1, write strobe from the core's data-memory bus.
REQ-005 SHALL have port iAddr, input, 32, byte address; decode uses iAddr[31:2] only.
REQ-006 SHALL have port iWrData, input, 32, write data.
REQ-007 SHALL have port oRdData, output, 32, read data.
REQ-008 SHALL have port oAccessable, output, 1, high when iAddr decodes to a register of this block.
REQ-009 SHALL have port oIrq, output, 1, timer interrupt request, level-sensitive.
REQ-010 SHALL have parameter BASE, default 32'h4000_0000, base address of the register window.

Function
REQ-011 Register map SHALL be: BASE+0x0 TH (RW), BASE+0x4 TL (RW), BASE+0x8 TCON (RW), BASE+0xC SYSTICK (RO).
REQ-012 TCON bits SHALL be: bit0 EN, bit1 IE, bit2 STATUS; bits 31:3 read as 0 and ignore writes.
REQ-013 oAccessable SHALL be combinational; high for exactly the four addresses above, regardless of iRd/iWr.
REQ-014 oRdData SHALL be combinational: selected register when iRd=1 and oAccessable=1, else 32'h0.
REQ-015 A write SHALL take effect at the rising edge where iWr=1 and oAccessable=1; read-back is visible from the next cycle.
REQ-016 Writes to SYSTICK or to unmapped addresses SHALL be ignored with no side effect.
REQ-017 iRd and iWr high together SHALL perform both: read returns the pre-write value, the write commits at the edge.
REQ-018 SYSTICK SHALL increment by 1 every cycle after reset, wrapping 32'hFFFF_FFFF -> 0.
REQ-019 While EN=1, TL SHALL increment by 1 every cycle.
REQ-020 When EN=1 and TL==32'hFFFF_FFFF, at the next edge TL SHALL load TH and STATUS SHALL set to 1 (overflow event).
REQ-021 While EN=0, TL, TH and STATUS SHALL hold except for bus writes.
REQ-022 A bus write to TL in the same cycle as counting or overflow SHALL win for TL; STATUS SHALL still set if overflow occurred.
REQ-023 A bus write to TCON SHALL load EN, IE and STATUS from iWrData[2:0]; an overflow in the same cycle SHALL force STATUS=1 (hardware set wins over software clear).
REQ-024 A bus write to TH SHALL not affect TL; the new TH applies at the next reload.
REQ-025 oIrq SHALL equal IE AND STATUS, registered-state driven (no combinational path from bus inputs).
REQ-026 Overflow period with constant TH SHALL be (2^32 - TH) cycles after the first reload.

Reset
REQ-027 On iRst_n=0, TH, TL, TCON and SYSTICK SHALL clear to 0 immediately, independent of iClk.
REQ-028 During reset oIrq SHALL be 0; oRdData and oAccessable SHALL follow REQ-013/014 with zeroed registers.
REQ-029 Reset asserted mid-count SHALL abandon the count; after release the timer stays disabled until EN is written.

Structure
REQ-030 Register offsets, TCON bit indices and the default BASE SHALL live in a shared peripheral package used by the data-memory decoder and by the bench.
REQ-031 The TH/TL reload counter (inputs EN, TH, load strobe/data; outputs TL, overflow pulse) SHALL be a single sub-module named timer_counter; decode, TCON and SYSTICK stay in periph_timer.

Verification
REQ-032 Reset then read BASE+0x8 and BASE+0x0 -> 0 and 0; oIrq=0; read BASE+0x10 -> oAccessable=0, oRdData=0.
REQ-033 Write TH=32'hFFFF_FFF0, TL=32'hFFFF_FFFE, TCON=3 -> overflow 2 cycles later, TL=32'hFFFF_FFF0, STATUS=1, oIrq=1; next overflow exactly 16 cycles later.
REQ-034 With STATUS=1, write TCON=3 in the exact overflow cycle -> STATUS reads 1 and oIrq stays 1; write TCON=3 in a non-overflow cycle -> STATUS=0, oIrq=0.
REQ-035 EN=1, write TL=32'h1234 in the overflow cycle -> TL reads 32'h1235 the following cycle and STATUS=1.
REQ-036 Write 32'hDEAD_BEEF to BASE+0xC -> SYSTICK unaffected, keeps incrementing by 1 per cycle between two reads.
REQ-037 Assert iRst_n low asynchronously between edges while counting -> all registers 0 and oIrq=0 before the next edge; no counting after release.
